ex_stage_pipe: RTL and testbench
================================

// Module: ex_stage_pipe
// PURPOSE
//  Parametrised execute stage for the pipelined CPU: operand forwarding, ALU, flag register,
//  iterative multiplier and the EX/MEM pipeline register with valid/ready flow control.
//  Sits between the ID/EX register and the MEM stage; drives data hazard resolution locally.
// PARAMETERS
//  W      16  datapath width (even, >=16)
//  RA     4   register address width
//  SHW    4   shift-amount width ($clog2(W))
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous reset, active-low
//  in_valid     in   1     ID/EX holds a valid instruction
//  in_ready     out  1     stage accepts instruction this cycle
//  op           in   4     ALU op: ADD0 SUB1 NAND2 XOR3 MUL4 SRA5 SRL6 SLL7 LHBA LLBB
//  alu_src      in   2     b select: 0 rt operand, 1 imm, 2 offset, 3 constant 1
//  rs_addr      in   RA    source a register
//  rt_addr      in   RA    source b register
//  rd_addr      in   RA    destination register
//  rs_data      in   W     register-file value of rs
//  rt_data      in   W     register-file value of rt
//  imm          in   W     sign-extended immediate; imm[SHW-1:0] = shift amount
//  offset       in   W     branch/memory offset
//  pc_inc       in   W     PC+1 of the instruction
//  wb_en_in     in   1     instruction writes rd
//  mem_ctl_in   in   2     MEM-stage control, passed through
//  mw_wr_en     in   1     MEM/WB writes register
//  mw_rd        in   RA    MEM/WB destination
//  mw_data      in   W     MEM/WB writeback value
//  flush        in   1     squash stage contents (branch mispredict)
//  out_valid    out  1     EX/MEM register holds valid result
//  out_ready    in   1     MEM stage accepts result
//  result       out  W     ALU/MUL result
//  store_data   out  W     forwarded rt value (store data)
//  rd_out       out  RA    destination
//  wb_en_out    out  1     registered wb_en_in
//  mem_ctl_out  out  2     registered mem_ctl_in
//  pc_branch    out  W     pc_inc + offset (mod 2^W)
//  flags        out  3     {zr,neg,ov}, architectural flag register
//  busy         out  1     multiplier running
// BEHAVIOUR
//  Reset (rst==0 at edge): every output/register 0, FSM IDLE; in_ready=0 while rst==0.
//  Accept = in_valid & in_ready; in_ready = rst & ~busy & ~flush & (~out_valid | out_ready).
//  Forwarding per source (a=rs, b-path rt): addr 0 -> always 0; else EX/MEM (out_valid &
//   wb_en_out & rd_out==addr) > MEM/WB (mw_wr_en & mw_rd==addr) > register-file data.
//  Single-cycle ops: accepted at edge N -> result/out_valid visible after edge N (1 cycle).
//  LHB: {b[W/2-1:0], a[W/2-1:0]}; LLB: {a[W-1:W/2], b[W/2-1:0]}; shifts use imm[SHW-1:0];
//   SRA arithmetic; undefined op codes -> result 0, flags unchanged.
//  Flags written on accept of ADD/SUB/NAND/XOR/MUL only; shifts, LHB, LLB keep flags.
//   ov ADD/SUB: signed overflow (SUB uses ~b sign); NAND/XOR ov=0; zr=~|result; neg=result[W-1].
//  MUL: FSM IDLE->MUL on accept (operands latched, forwarding resolved at accept);
//   shift-add, one bit/cycle, W cycles; busy=1 throughout; MUL->IDLE at completion edge
//   N+W, which loads EX/MEM register and flags; MUL ov=1 if upper W product bits !=0.
//  Completion blocked (stays in MUL, counter held) while out_valid & ~out_ready.
//  Stall: out_valid & ~out_ready -> all EX/MEM outputs and flags hold.
//  Output handoff: out_ready & out_valid with no new accept/completion -> out_valid=0 next.
//  flush: next edge out_valid=0, MUL aborted to IDLE, flags untouched; input that cycle
//   dropped. flush has priority over accept, completion and stall.
// TESTING
//  ADD 0x7FFF + 0x0001 (alu_src=0) -> next cycle result 0x8000, flags=3'b011, out_valid=1.
//  ADD r3<=5 then SUB r4=r3-r3 back-to-back (rf stale 0x1234) -> result 0, flags=3'b100.
//  MUL 0x0100*0x0100 -> busy/in_ready=0 16 cycles, then result 0x0000, flags=3'b101.
//  SLL imm=4 on 0x0F0F after SUB set zr -> result 0xF0F0, flags still 3'b100.
//  out_ready=0 for 3 cycles with in_valid=1 -> outputs constant, in_ready=0, no op lost.
//  flush at MUL cycle 7, and rst=0 mid-MUL -> busy=0 and out_valid=0 next cycle; flags kept on flush, 0 on reset.

Source files
------------

// File: rtl/ex_stage_pipe_if.sv
// Execute-stage bus: ID/EX instruction fields, MEM/WB forwarding source,
// and the EX/MEM result register seen by the MEM stage.
interface ex_stage_pipe_if #(
  parameter int W  = 16,
  parameter int RA = 4
);
  // upstream (ID/EX) handshake and instruction fields
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [1:0]    alu_src;
  logic [RA-1:0] rs_addr;
  logic [RA-1:0] rt_addr;
  logic [RA-1:0] rd_addr;
  logic [W-1:0]  rs_data;
  logic [W-1:0]  rt_data;
  logic [W-1:0]  imm;
  logic [W-1:0]  offset;
  logic [W-1:0]  pc_inc;
  logic          wb_en_in;
  logic [1:0]    mem_ctl_in;
  // MEM/WB writeback, used as a forwarding source
  logic          mw_wr_en;
  logic [RA-1:0] mw_rd;
  logic [W-1:0]  mw_data;
  // branch mispredict squash
  logic          flush;
  // downstream (EX/MEM) handshake and payload
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [W-1:0]  store_data;
  logic [RA-1:0] rd_out;
  logic          wb_en_out;
  logic [1:0]    mem_ctl_out;
  logic [W-1:0]  pc_branch;
  logic [2:0]    flags;
  logic          busy;

  // the execute stage itself
  modport slave (
    input  in_valid, op, alu_src, rs_addr, rt_addr, rd_addr, rs_data, rt_data,
           imm, offset, pc_inc, wb_en_in, mem_ctl_in, mw_wr_en, mw_rd, mw_data,
           flush, out_ready,
    output in_ready, out_valid, result, store_data, rd_out, wb_en_out,
           mem_ctl_out, pc_branch, flags, busy
  );

  // the surrounding pipeline (or a bench) driving the stage
  modport master (
    output in_valid, op, alu_src, rs_addr, rt_addr, rd_addr, rs_data, rt_data,
           imm, offset, pc_inc, wb_en_in, mem_ctl_in, mw_wr_en, mw_rd, mw_data,
           flush, out_ready,
    input  in_ready, out_valid, result, store_data, rd_out, wb_en_out,
           mem_ctl_out, pc_branch, flags, busy
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// Execute stage: operand forwarding, ALU, architectural flag register,
// W-cycle shift-add multiplier and the EX/MEM register with valid/ready flow.
module ex_stage_pipe #(
  parameter int W   = 16,
  parameter int RA  = 4,
  parameter int SHW = 4
) (
  input  logic           clk,
  input  logic           rst,
  ex_stage_pipe_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_SRA  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam int         CW      = $clog2(W);

  typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_t;

  // EX/MEM register
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  result_q,    result_d;
  logic [W-1:0]  store_q,     store_d;
  logic [RA-1:0] rd_q,        rd_d;
  logic          wb_en_q,     wb_en_d;
  logic [1:0]    mem_ctl_q,   mem_ctl_d;
  logic [W-1:0]  pc_br_q,     pc_br_d;
  logic [2:0]    flags_q,     flags_d;

  // multiplier state and the instruction fields it carries to completion
  state_t        state_q;
  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [2*W-1:0] prod_q;
  logic [W-1:0]  mcand_q;
  logic [W-1:0]  m_store_q;
  logic [RA-1:0] m_rd_q;
  logic          m_wb_q;
  logic [1:0]    m_mem_ctl_q;
  logic [W-1:0]  m_pc_br_q;

  // operand paths: index 0 is rs (a), index 1 is rt (b-path, store data)
  logic [RA-1:0] src_addr [2];
  logic [W-1:0]  src_rf   [2];
  logic [W-1:0]  src_fwd  [2];

  logic [W-1:0]  a_op;
  logic [W-1:0]  rt_op;
  logic [W-1:0]  b_op;
  logic [SHW-1:0] shamt;
  logic [W-1:0]  alu_res;
  logic          alu_ov;
  logic          alu_flag_we;
  logic [W-1:0]  pc_br_calc;

  logic          in_ready;
  logic          accept;
  logic          stall;
  logic          mul_last;
  logic          mul_done;
  logic [W:0]    mul_sum;
  logic [2*W-1:0] prod_step;

  assign src_addr[0] = bus.rs_addr;
  assign src_addr[1] = bus.rt_addr;
  assign src_rf[0]   = bus.rs_data;
  assign src_rf[1]   = bus.rt_data;

  // r0 reads as zero; the younger EX/MEM result beats MEM/WB, which beats the file
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign src_fwd[gi] =
        (src_addr[gi] == '0) ? '0 :
        (out_valid_q && wb_en_q && (rd_q == src_addr[gi])) ? result_q :
        (bus.mw_wr_en && (bus.mw_rd == src_addr[gi])) ? bus.mw_data :
        src_rf[gi];
    end
  endgenerate

  assign a_op  = src_fwd[0];
  assign rt_op = src_fwd[1];
  assign shamt = bus.imm[SHW-1:0];
  assign pc_br_calc = bus.pc_inc + bus.offset;

  // b operand select
  always_comb begin
    b_op = rt_op;
    case (bus.alu_src)
      2'd0:    b_op = rt_op;
      2'd1:    b_op = bus.imm;
      2'd2:    b_op = bus.offset;
      default: b_op = {{(W-1){1'b0}}, 1'b1};
    endcase
  end

  // single-cycle ALU; only arithmetic/logic ops update the flag register
  always_comb begin
    alu_res     = '0;
    alu_ov      = 1'b0;
    alu_flag_we = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res     = a_op + b_op;
        alu_ov      = (a_op[W-1] == b_op[W-1]) && (alu_res[W-1] != a_op[W-1]);
        alu_flag_we = 1'b1;
      end
      OP_SUB: begin
        alu_res     = a_op - b_op;
        alu_ov      = (a_op[W-1] != b_op[W-1]) && (alu_res[W-1] != a_op[W-1]);
        alu_flag_we = 1'b1;
      end
      OP_NAND: begin
        alu_res     = ~(a_op & b_op);
        alu_flag_we = 1'b1;
      end
      OP_XOR: begin
        alu_res     = a_op ^ b_op;
        alu_flag_we = 1'b1;
      end
      OP_SRA:  alu_res = $signed(a_op) >>> shamt;
      OP_SRL:  alu_res = a_op >> shamt;
      OP_SLL:  alu_res = a_op << shamt;
      OP_LHB:  alu_res = {b_op[W/2-1:0], a_op[W/2-1:0]};
      OP_LLB:  alu_res = {a_op[W-1:W/2], b_op[W/2-1:0]};
      default: alu_res = '0;
    endcase
  end

  assign in_ready = rst & ~busy_q & ~bus.flush & (~out_valid_q | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign stall    = out_valid_q & ~bus.out_ready;
  assign mul_last = (state_q == ST_MUL) && (cnt_q == CW'(W - 1));
  assign mul_done = mul_last & ~stall & ~bus.flush;

  // one shift-add step: add multiplicand into the high half when the low bit is set
  assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
  assign prod_step = {mul_sum, prod_q[W-1:1]};

  // EX/MEM next state: flush > multiplier completion > new accept > handoff > hold
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    store_d     = store_q;
    rd_d        = rd_q;
    wb_en_d     = wb_en_q;
    mem_ctl_d   = mem_ctl_q;
    pc_br_d     = pc_br_q;
    flags_d     = flags_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = prod_step[W-1:0];
      store_d     = m_store_q;
      rd_d        = m_rd_q;
      wb_en_d     = m_wb_q;
      mem_ctl_d   = m_mem_ctl_q;
      pc_br_d     = m_pc_br_q;
      flags_d     = {~|prod_step[W-1:0], prod_step[W-1], |prod_step[2*W-1:W]};
    end else if (accept && (bus.op != OP_MUL)) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      store_d     = rt_op;
      rd_d        = bus.rd_addr;
      wb_en_d     = bus.wb_en_in;
      mem_ctl_d   = bus.mem_ctl_in;
      pc_br_d     = pc_br_calc;
      if (alu_flag_we) begin
        flags_d = {~|alu_res, alu_res[W-1], alu_ov};
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // EX/MEM register update
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      store_q     <= '0;
      rd_q        <= '0;
      wb_en_q     <= 1'b0;
      mem_ctl_q   <= '0;
      pc_br_q     <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      store_q     <= store_d;
      rd_q        <= rd_d;
      wb_en_q     <= wb_en_d;
      mem_ctl_q   <= mem_ctl_d;
      pc_br_q     <= pc_br_d;
      flags_q     <= flags_d;
    end
  end

  // multiplier FSM: latch operands on accept, step once per cycle, hold the last step while stalled
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      m_store_q   <= '0;
      m_rd_q      <= '0;
      m_wb_q      <= 1'b0;
      m_mem_ctl_q <= '0;
      m_pc_br_q   <= '0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && (bus.op == OP_MUL)) begin
            state_q     <= ST_MUL;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            prod_q      <= {{W{1'b0}}, b_op};
            mcand_q     <= a_op;
            m_store_q   <= rt_op;
            m_rd_q      <= bus.rd_addr;
            m_wb_q      <= bus.wb_en_in;
            m_mem_ctl_q <= bus.mem_ctl_in;
            m_pc_br_q   <= pc_br_calc;
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            if (!stall) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            prod_q <= prod_step;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.result      = result_q;
  assign bus.store_data  = store_q;
  assign bus.rd_out      = rd_q;
  assign bus.wb_en_out   = wb_en_q;
  assign bus.mem_ctl_out = mem_ctl_q;
  assign bus.pc_branch   = pc_br_q;
  assign bus.flags       = flags_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Bench for ex_stage_pipe: directed scenarios with literal expectations,
// then randomized traffic against a transaction-level model of the stage.
module tb_ex_stage_pipe;
  localparam int W  = 16;
  localparam int RA = 4;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -(longint'(1) << (W - 1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_stage_pipe_if #(.W(W), .RA(RA)) bus ();
  ex_stage_pipe #(.W(W), .RA(RA), .SHW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          ov;
    logic [W-1:0]  res;
    logic [W-1:0]  sd;
    logic [W-1:0]  pcb;
    logic [RA-1:0] rd;
    logic          wb;
    logic [1:0]    mc;
    logic [2:0]    flags;
    logic          busy;
    int            left;
  } mstate_t;

  mstate_t        m;
  logic [2*W-1:0] p_prod;
  logic [W-1:0]   p_sd, p_pcb;
  logic [RA-1:0]  p_rd;
  logic           p_wb;
  logic [1:0]     p_mc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // architectural operand value as the stage must see it
  function automatic logic [W-1:0] m_fwd(input logic [RA-1:0] addr, input logic [W-1:0] rfv);
    if (addr == 0) return '0;
    if (m.ov && m.wb && m.rd == addr) return m.res;
    if (bus.mw_wr_en && bus.mw_rd == addr) return bus.mw_data;
    return rfv;
  endfunction

  function automatic void alu_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input int sh, output logic [W-1:0] res, output logic we,
                                    output logic ovf);
    longint s;
    res = '0; we = 1'b0; ovf = 1'b0; s = 0;
    case (op)
      4'h0: begin s = longint'($signed(a)) + longint'($signed(b)); res = s[W-1:0]; we = 1'b1; ovf = (s > MAXS) || (s < MINS); end
      4'h1: begin s = longint'($signed(a)) - longint'($signed(b)); res = s[W-1:0]; we = 1'b1; ovf = (s > MAXS) || (s < MINS); end
      4'h2: begin res = ~(a & b); we = 1'b1; end
      4'h3: begin res = a ^ b; we = 1'b1; end
      4'h5: begin s = longint'($signed(a)); s = s >>> sh; res = s[W-1:0]; end
      4'h6: res = a >> sh;
      4'h7: res = a << sh;
      4'hA: res = {b[W/2-1:0], a[W/2-1:0]};
      4'hB: res = {a[W-1:W/2], b[W/2-1:0]};
      default: res = '0;
    endcase
  endfunction

  // one clock: predict from the inputs before the edge, compare after it
  task automatic cycle();
    mstate_t n;
    logic exp_rdy, acc, stall, done, we, ovf;
    logic [W-1:0] a, rt, b, res;
    @(negedge clk);
    exp_rdy = rst && !m.busy && !bus.flush && (!m.ov || bus.out_ready);
    chk("in_ready", bus.in_ready, exp_rdy);
    acc = bus.in_valid && exp_rdy;
    if (rst && !bus.flush && m.ov && bus.out_ready)
      $display("xfer result=%h store=%h rd=%0d wb=%b flags=%b", m.res, m.sd, m.rd, m.wb, m.flags);
    n = m;
    if (!rst) begin
      n.ov = 0; n.res = 0; n.sd = 0; n.pcb = 0; n.rd = 0; n.wb = 0; n.mc = 0;
      n.flags = 0; n.busy = 0; n.left = 0;
    end else if (bus.flush) begin
      n.ov = 0; n.busy = 0; n.left = 0;
    end else begin
      stall = m.ov && !bus.out_ready;
      done  = m.busy && m.left == 1 && !stall;
      if (done) begin
        n.ov = 1; n.busy = 0; n.left = 0;
        n.res = p_prod[W-1:0]; n.sd = p_sd; n.rd = p_rd; n.wb = p_wb; n.mc = p_mc; n.pcb = p_pcb;
        n.flags = {p_prod[W-1:0] == 0, p_prod[W-1], (p_prod >> W) != 0};
      end else if (m.busy && m.left > 1) begin
        n.left = m.left - 1;
      end
      if (acc) begin
        a  = m_fwd(bus.rs_addr, bus.rs_data);
        rt = m_fwd(bus.rt_addr, bus.rt_data);
        case (bus.alu_src)
          2'd0: b = rt;
          2'd1: b = bus.imm;
          2'd2: b = bus.offset;
          default: b = 1;
        endcase
        if (bus.op == 4'h4) begin
          n.busy = 1; n.left = W;
          p_prod = (2*W)'(a) * (2*W)'(b);
          p_sd = rt; p_rd = bus.rd_addr; p_wb = bus.wb_en_in; p_mc = bus.mem_ctl_in;
          p_pcb = bus.pc_inc + bus.offset;
          if (m.ov && bus.out_ready) n.ov = 0;
        end else begin
          alu_model(bus.op, a, b, int'(bus.imm[3:0]), res, we, ovf);
          n.ov = 1; n.res = res; n.sd = rt; n.rd = bus.rd_addr; n.wb = bus.wb_en_in;
          n.mc = bus.mem_ctl_in; n.pcb = bus.pc_inc + bus.offset;
          if (we) n.flags = {res == 0, res[W-1], ovf};
        end
      end else if (!done && m.ov && bus.out_ready) begin
        n.ov = 0;
      end
    end
    @(posedge clk);
    #1;
    m = n;
    chk("out_valid", bus.out_valid, m.ov);
    chk("busy", bus.busy, m.busy);
    chk("flags", bus.flags, m.flags);
    if (m.ov) begin
      chk("result", bus.result, m.res);
      chk("store_data", bus.store_data, m.sd);
      chk("rd_out", bus.rd_out, m.rd);
      chk("wb_en_out", bus.wb_en_out, m.wb);
      chk("mem_ctl_out", bus.mem_ctl_out, m.mc);
      chk("pc_branch", bus.pc_branch, m.pcb);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.op = 0; bus.alu_src = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    bus.rd_addr = 0; bus.rs_data = 0; bus.rt_data = 0; bus.imm = 0; bus.offset = 0;
    bus.pc_inc = 0; bus.wb_en_in = 0; bus.mem_ctl_in = 0; bus.mw_wr_en = 0; bus.mw_rd = 0;
    bus.mw_data = 0; bus.flush = 0; bus.out_ready = 1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] src, input logic [RA-1:0] rs,
                       input logic [RA-1:0] rt, input logic [RA-1:0] rd, input logic [W-1:0] rsd,
                       input logic [W-1:0] rtd, input logic [W-1:0] immv);
    bus.in_valid = 1; bus.op = op; bus.alu_src = src; bus.rs_addr = rs; bus.rt_addr = rt;
    bus.rd_addr = rd; bus.rs_data = rsd; bus.rt_data = rtd; bus.imm = immv;
    bus.offset = 16'h0003; bus.pc_inc = 16'h0010; bus.wb_en_in = 1; bus.mem_ctl_in = 2'b01;
  endtask

  initial begin
    m = '{default: 0};
    p_prod = 0; p_sd = 0; p_pcb = 0; p_rd = 0; p_wb = 0; p_mc = 0;
    idle_inputs();

    // reset state
    rst = 0;
    repeat (3) cycle();
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, 16'h0000);
    chk("rst_flags", bus.flags, 3'b000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    rst = 1;
    cycle();

    // signed overflow on ADD
    issue(4'h0, 2'd0, 4'd1, 4'd2, 4'd5, 16'h7FFF, 16'h0001, 16'h0000);
    cycle(); bus.in_valid = 0;
    $display("txn ADD 7fff+0001 result=%h flags=%b", bus.result, bus.flags);
    chk("add_ov_result", bus.result, 16'h8000);
    chk("add_ov_flags", bus.flags, 3'b011);
    chk("add_ov_valid", bus.out_valid, 1'b1);
    chk("add_ov_pcbr", bus.pc_branch, 16'h0013);

    // back-to-back dependency through EX/MEM forwarding
    issue(4'h0, 2'd0, 4'd1, 4'd2, 4'd3, 16'h0002, 16'h0003, 16'h0000);
    cycle();
    issue(4'h1, 2'd0, 4'd3, 4'd3, 4'd4, 16'h1234, 16'h1234, 16'h0000);
    cycle(); bus.in_valid = 0;
    $display("txn SUB r3-r3 result=%h flags=%b", bus.result, bus.flags);
    chk("fwd_sub_result", bus.result, 16'h0000);
    chk("fwd_sub_flags", bus.flags, 3'b100);

    // shift keeps flags
    issue(4'h7, 2'd1, 4'd6, 4'd0, 4'd7, 16'h0F0F, 16'h0000, 16'h0004);
    cycle(); bus.in_valid = 0;
    $display("txn SLL 0f0f<<4 result=%h flags=%b", bus.result, bus.flags);
    chk("sll_result", bus.result, 16'hF0F0);
    chk("sll_flags", bus.flags, 3'b100);

    // multiply occupies W cycles
    issue(4'h4, 2'd0, 4'd6, 4'd8, 4'd10, 16'h0100, 16'h0100, 16'h0000);
    cycle(); bus.in_valid = 0;
    chk("mul_busy_1", bus.busy, 1'b1);
    chk("mul_rdy_1", bus.in_ready, 1'b0);
    for (int i = 2; i <= W; i++) begin
      cycle();
      chk("mul_busy_n", bus.busy, 1'b1);
      chk("mul_rdy_n", bus.in_ready, 1'b0);
    end
    cycle();
    $display("txn MUL 0100*0100 result=%h flags=%b", bus.result, bus.flags);
    chk("mul_done_busy", bus.busy, 1'b0);
    chk("mul_result", bus.result, 16'h0000);
    chk("mul_flags", bus.flags, 3'b101);
    chk("mul_valid", bus.out_valid, 1'b1);

    // downstream stall with a waiting instruction
    bus.out_ready = 0;
    issue(4'h0, 2'd0, 4'd1, 4'd2, 4'd11, 16'h0005, 16'h0006, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_rdy", bus.in_ready, 1'b0);
      chk("stall_result", bus.result, 16'h0000);
      chk("stall_valid", bus.out_valid, 1'b1);
      chk("stall_flags", bus.flags, 3'b101);
    end
    bus.out_ready = 1;
    cycle(); bus.in_valid = 0;
    $display("txn ADD after stall result=%h flags=%b", bus.result, bus.flags);
    chk("post_stall_result", bus.result, 16'h000B);
    chk("post_stall_rd", bus.rd_out, 4'd11);
    chk("post_stall_flags", bus.flags, 3'b000);

    // flush during a multiply keeps flags
    issue(4'h1, 2'd0, 4'd1, 4'd2, 4'd12, 16'h0009, 16'h0009, 16'h0000);
    cycle();
    issue(4'h4, 2'd0, 4'd1, 4'd2, 4'd13, 16'h0003, 16'h0005, 16'h0000);
    cycle(); bus.in_valid = 0;
    repeat (6) cycle();
    bus.flush = 1;
    cycle(); bus.flush = 0;
    $display("txn MUL flushed busy=%b valid=%b flags=%b", bus.busy, bus.out_valid, bus.flags);
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_flags", bus.flags, 3'b100);
    repeat (W + 2) cycle();
    chk("flush_no_late_result", bus.out_valid, 1'b0);

    // reset during a multiply
    issue(4'h4, 2'd0, 4'd1, 4'd2, 4'd13, 16'h0003, 16'h0005, 16'h0000);
    cycle(); bus.in_valid = 0;
    repeat (4) cycle();
    rst = 0;
    cycle();
    $display("txn MUL reset busy=%b valid=%b flags=%b", bus.busy, bus.out_valid, bus.flags);
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_valid", bus.out_valid, 1'b0);
    chk("mrst_flags", bus.flags, 3'b000);
    chk("mrst_rdy", bus.in_ready, 1'b0);
    rst = 1;
    cycle();

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) != 0);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.op        = 4'($urandom_range(0, 15));
      if (bus.op == 4'h4 && $urandom_range(0, 2) != 0) bus.op = 4'($urandom_range(0, 3));
      bus.alu_src    = 2'($urandom_range(0, 3));
      bus.rs_addr    = 4'($urandom_range(0, 3));
      bus.rt_addr    = 4'($urandom_range(0, 3));
      bus.rd_addr    = 4'($urandom_range(0, 3));
      bus.rs_data    = 16'($urandom);
      bus.rt_data    = 16'($urandom);
      bus.imm        = 16'($urandom);
      bus.offset     = 16'($urandom);
      bus.pc_inc     = 16'($urandom);
      bus.wb_en_in   = 1'($urandom_range(0, 1));
      bus.mem_ctl_in = 2'($urandom_range(0, 3));
      bus.mw_wr_en   = 1'($urandom_range(0, 1));
      bus.mw_rd      = 4'($urandom_range(0, 3));
      bus.mw_data    = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
